// File: rtl/cpu_types_pkg.sv
// Shared encodings for the memory-side control path: RAM status, arbiter
// state and last-grant tracking.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter between the icache and dcache: one grant at a time,
// optional round-robin on ties and an abort-on-timeout for stuck grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit FAIR    = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout_err
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  arb_state_t state;
  grant_t     last;
  logic [7:0] count;

  logic d_req;
  logic i_req;
  logic access;
  logic granted_req;
  logic cnt_expired;
  logic prefer_i;

  assign d_req       = dREN | dWEN;
  assign i_req       = iREN;
  assign access      = (ramstate_t'(ramstate) == ACCESS);
  assign granted_req = (state == DGRANT) ? d_req : i_req;
  assign prefer_i    = FAIR && i_req && (last == GRANT_D);

  // The grant is held for exactly TIMEOUT cycles before giving up.
  assign cnt_expired = (TIMEOUT != 0) && (({1'b0, count} + 9'd1) == TIMEOUT_LIM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      last        <= GRANT_I;
      count       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          count <= '0;
          if (d_req && !prefer_i) begin
            state <= DGRANT;
          end else if (i_req) begin
            state <= IGRANT;
          end
        end
        DGRANT, IGRANT: begin
          // A dropped request wins over a same-cycle ACCESS: no completion.
          if (!granted_req) begin
            state <= IDLE;
          end else if (access) begin
            state <= IDLE;
            last  <= (state == DGRANT) ? GRANT_D : GRANT_I;
          end else if (cnt_expired) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            count <= count + 8'(count != 8'hFF);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state so ACCESS is answered in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    unique case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (d_req && access) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (i_req && access) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fair default instance, a data-priority
// instance and a short-timeout instance all share one set of stimulus.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic        iwait, dwait, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        nf_iwait, nf_dwait, nf_ramREN, nf_ramWEN, nf_timeout_err;
  logic [31:0] nf_iload, nf_dload, nf_ramaddr, nf_ramstore;
  logic        to_iwait, to_dwait, to_ramREN, to_ramWEN, to_timeout_err;
  logic [31:0] to_iload, to_dload, to_ramaddr, to_ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
  );

  mem_arbiter #(.FAIR(1'b0)) dut_nf (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(nf_iwait), .iload(nf_iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(nf_dwait), .dload(nf_dload),
    .ramREN(nf_ramREN), .ramWEN(nf_ramWEN), .ramaddr(nf_ramaddr), .ramstore(nf_ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout_err(nf_timeout_err)
  );

  mem_arbiter #(.TIMEOUT(4)) dut_to (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(to_iwait), .iload(to_iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(to_dwait), .dload(to_dload),
    .ramREN(to_ramREN), .ramWEN(to_ramWEN), .ramaddr(to_ramaddr), .ramstore(to_ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout_err(to_timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic i_r, input logic d_r, input logic d_w,
                                input logic [1:0] st);
    iREN     = i_r;
    dREN     = d_r;
    dWEN     = d_w;
    ramstate = st;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    apply_stimulus(1'b0, 1'b0, 1'b0, FREE);
    #3;
    check_bit("rst_iwait", iwait, 1'b1);
    check_bit("rst_dwait", dwait, 1'b1);
    check_bit("rst_ramREN", ramREN, 1'b0);
    check_bit("rst_ramWEN", ramWEN, 1'b0);
    check_bit("rst_timeout_err", timeout_err, 1'b0);
    check_output("rst_ramaddr", ramaddr, 32'h0);
    check_output("rst_ramstore", ramstore, 32'h0);
    check_output("rst_iload", iload, 32'h0);
    check_output("rst_dload", dload, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Single instruction fill: arbitration cycle, then ACCESS.
    @(negedge CLK);
    iaddr = 32'h40;
    apply_stimulus(1'b1, 1'b0, 1'b0, FREE);
    #1;
    check_bit("rd_arb_iwait", iwait, 1'b1);
    check_bit("rd_arb_ramREN", ramREN, 1'b0);
    @(negedge CLK);
    ramstate = ACCESS;
    ramload  = 32'hDEADBEEF;
    #1;
    check_bit("rd_ramREN", ramREN, 1'b1);
    check_output("rd_ramaddr", ramaddr, 32'h40);
    check_bit("rd_iwait", iwait, 1'b0);
    check_output("rd_iload", iload, 32'hDEADBEEF);
    check_bit("rd_dwait", dwait, 1'b1);
    check_output("rd_dload", dload, 32'h0);
    @(negedge CLK);
    apply_stimulus(1'b0, 1'b0, 1'b0, FREE);
    ramload = '0;
    #1;
    check_bit("rd_done_iwait", iwait, 1'b1);
    check_bit("rd_done_ramREN", ramREN, 1'b0);

    // Tie: fair instance alternates D,I,D,I; data-priority instance always D.
    @(negedge CLK);
    iaddr = 32'h80;
    daddr = 32'h180;
    apply_stimulus(1'b1, 1'b1, 1'b0, ACCESS);
    for (int k = 0; k < 4; k++) begin
      logic d_turn;
      logic [31:0] word;
      d_turn = ((k % 2) == 0);
      word = 32'h1000 + 32'(k);
      @(negedge CLK);
      ramload = word;
      #1;
      check_bit($sformatf("tie%0d_dwait", k), dwait, !d_turn);
      check_bit($sformatf("tie%0d_iwait", k), iwait, d_turn);
      check_output($sformatf("tie%0d_ramaddr", k), ramaddr, d_turn ? 32'h180 : 32'h80);
      check_output($sformatf("tie%0d_load", k), d_turn ? dload : iload, word);
      check_bit($sformatf("tie%0d_nf_dwait", k), nf_dwait, 1'b0);
      check_bit($sformatf("tie%0d_nf_iwait", k), nf_iwait, 1'b1);
      @(negedge CLK);
      #1;
      check_bit($sformatf("tie%0d_arb_dwait", k), dwait, 1'b1);
      check_bit($sformatf("tie%0d_arb_iwait", k), iwait, 1'b1);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, FREE);

    // Write, with a late dREN to show write precedence.
    @(negedge CLK);
    daddr  = 32'h100;
    dstore = 32'h12345678;
    apply_stimulus(1'b0, 1'b0, 1'b1, BUSY);
    #1;
    check_bit("wr_arb_ramWEN", ramWEN, 1'b0);
    @(negedge CLK);
    #1;
    check_bit("wr_ramWEN", ramWEN, 1'b1);
    check_bit("wr_ramREN", ramREN, 1'b0);
    check_output("wr_ramaddr", ramaddr, 32'h100);
    check_output("wr_ramstore", ramstore, 32'h12345678);
    check_bit("wr_busy_dwait", dwait, 1'b1);
    @(negedge CLK);
    apply_stimulus(1'b0, 1'b1, 1'b1, ACCESS);
    #1;
    check_bit("wr_both_ramWEN", ramWEN, 1'b1);
    check_bit("wr_both_ramREN", ramREN, 1'b0);
    check_bit("wr_dwait", dwait, 1'b0);
    @(negedge CLK);
    apply_stimulus(1'b0, 1'b0, 1'b0, FREE);
    #1;
    check_bit("wr_done_dwait", dwait, 1'b1);
    check_bit("wr_done_ramWEN", ramWEN, 1'b0);

    // Abort: dREN dropped while BUSY.
    @(negedge CLK);
    daddr = 32'h200;
    apply_stimulus(1'b0, 1'b1, 1'b0, BUSY);
    @(negedge CLK);
    #1;
    check_bit("ab_ramREN", ramREN, 1'b1);
    check_bit("ab_dwait", dwait, 1'b1);
    @(negedge CLK);
    dREN = 1'b0;
    #1;
    check_bit("ab_drop_dwait", dwait, 1'b1);
    @(negedge CLK);
    apply_stimulus(1'b0, 1'b1, 1'b0, ACCESS);
    #1;
    check_bit("ab_idle_dwait", dwait, 1'b1);
    check_bit("ab_idle_ramREN", ramREN, 1'b0);
    @(negedge CLK);
    #1;
    check_bit("ab_regrant_dwait", dwait, 1'b0);
    @(negedge CLK);
    apply_stimulus(1'b0, 1'b0, 1'b0, FREE);

    // Timeout on the TIMEOUT=4 instance with RAM stuck BUSY.
    @(negedge CLK);
    daddr = 32'h280;
    apply_stimulus(1'b0, 1'b1, 1'b0, BUSY);
    #1;
    check_bit("to_arb_err", to_timeout_err, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      #1;
      check_bit($sformatf("to_c%0d_ramREN", k), to_ramREN, 1'b1);
      check_bit($sformatf("to_c%0d_err", k), to_timeout_err, 1'b0);
    end
    @(negedge CLK);
    #1;
    check_bit("to_pulse", to_timeout_err, 1'b1);
    check_bit("to_idle_ramREN", to_ramREN, 1'b0);
    check_bit("to_idle_dwait", to_dwait, 1'b1);
    check_bit("to_default_err", timeout_err, 1'b0);
    dREN = 1'b0;
    @(negedge CLK);
    #1;
    check_bit("to_pulse_end", to_timeout_err, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, FREE);

    // Reset asserted in the middle of an instruction grant.
    @(negedge CLK);
    iaddr = 32'h300;
    apply_stimulus(1'b1, 1'b0, 1'b0, BUSY);
    @(negedge CLK);
    #1;
    check_bit("rg_ramREN", ramREN, 1'b1);
    check_output("rg_ramaddr", ramaddr, 32'h300);
    #1;
    nRST = 1'b0;
    #1;
    check_bit("rg_rst_ramREN", ramREN, 1'b0);
    check_bit("rg_rst_iwait", iwait, 1'b1);
    check_output("rg_rst_ramaddr", ramaddr, 32'h0);
    iREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // After reset the data port wins the first tie again.
    @(negedge CLK);
    ramload = 32'h77;
    apply_stimulus(1'b1, 1'b1, 1'b0, ACCESS);
    @(negedge CLK);
    #1;
    check_bit("post_rst_dwait", dwait, 1'b0);
    check_bit("post_rst_iwait", iwait, 1'b1);
    check_output("post_rst_dload", dload, 32'h77);
    @(negedge CLK);
    apply_stimulus(1'b0, 1'b0, 1'b0, FREE);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
